store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- FIFO of committed stores between the memory-stage pipeline and the byte-addressed data RAM.
- Stores retire from the pipeline in one cycle; the buffer drains them to the RAM whenever the RAM port is not needed by a load.
- Loads that overlap buffered stores are forwarded or stalled, so the RAM never returns stale data.
- Halfword stores are split into two byte writes, because the RAM write path supports only word and byte writes.

Parameters:
- DEPTH, 4: buffer entries; power of two, at least 2.
- ADDRESS_WIDTH, 32: byte address width.
- DATA_WIDTH, 32: store and load data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- st_valid  in  1  store request from the pipeline.
- st_ready  out  1  buffer can accept a store; high when count < DEPTH.
- st_addr  in  ADDRESS_WIDTH  store byte address.
- st_data  in  DATA_WIDTH  store data, LSB-aligned.
- st_type  in  2  00 word, 01 byte, 10 halfword.
- ld_valid  in  1  load request.
- ld_addr  in  ADDRESS_WIDTH  load byte address.
- ld_type  in  2  load size, same encoding as st_type.
- ld_hit  out  1  load satisfied by forwarding; pipeline selects fwd_data.
- ld_stall  out  1  partial overlap; pipeline holds the load.
- fwd_data  out  DATA_WIDTH  forwarded data, zero-extended to match RAM RD.
- ram_WE  out  1  RAM write enable.
- ram_A  out  ADDRESS_WIDTH  RAM address; shared by loads and drains.
- ram_WD  out  DATA_WIDTH  RAM write data.
- ram_dataType  out  2  RAM access size.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset: all entries invalid; head, tail, count and half_phase = 0. After reset: ram_WE=0, ld_hit=0, ld_stall=0, fwd_data=0, st_ready=1.
- Enqueue: st_valid && st_ready writes {addr, data, type} at the tail; tail++ modulo DEPTH. The entry is visible from the next cycle.
- st_ready is computed from registered count only; a drain in the same cycle does not free a slot until the next cycle.
- st_valid && !st_ready: the store is dropped; the pipeline is responsible for holding it.
- st_valid and ld_valid must not both be high in the same cycle. If they are, the store wins and the load is ignored (ld_hit=0, ld_stall=0).
- Load overlap check (combinational): each entry spans bytes [addr, addr+size-1], size 4/1/2, address arithmetic modulo 2^ADDRESS_WIDTH. Select the youngest valid entry whose span overlaps the load span.
  - No overlap: ld_hit=0, ld_stall=0. ram_A=ld_addr, ram_dataType=ld_type, ram_WE=0. No drain this cycle.
  - Youngest overlapping entry has addr==ld_addr and size >= load size: ld_hit=1. fwd_data = the entry data's low load-size bytes, zero-extended. RAM is free, so a drain may proceed.
  - Any other overlap: ld_stall=1, ld_hit=0. A drain proceeds; the pipeline retries the load each cycle until it becomes a hit or a miss.
- Drain: happens when count>0 and the RAM is not used by a missing load. Drive ram_WE=1 and ram_A=head.addr.
  - Word entry: ram_dataType=00, ram_WD=data. head++, count-- at the edge.
  - Byte entry: ram_dataType=01, ram_WD={24'b0, data[7:0]}. head++, count--.
  - Halfword entry, half_phase=0: byte write data[7:0] at addr; half_phase<=1. The entry stays valid and still forwards.
  - Halfword entry, half_phase=1: byte write of data[15:8] at addr+1 (with wrap); half_phase<=0, head++, count--.
- Simultaneous enqueue and dequeue in one cycle: count unchanged.
- Drain throughput: one RAM write per cycle. Store-to-RAM latency is at least 1 cycle for word/byte entries and at least 2 for halfword entries.
- rst asserted mid-drain: state is cleared at the edge, and any in-flight halfword second byte is abandoned (flush semantics).
- Unknown type 11 is treated as word.

Decomposition:
- Shared package mem_pkg holds:
  - mem_type_t enum: MEM_WORD=2'b00, MEM_BYTE=2'b01, MEM_HALF=2'b10;
  - function type_size(mem_type_t) returning 4/1/2;
  - sb_entry_t struct {valid, addr, data, type}.
- One sub-module, sb_overlap, is natural. It is a per-entry range comparator outputting overlap and exact_cover.
- Youngest-match selection is a priority scan from tail-1 back toward head, inside store_buffer.

Test Plan:
- Reset, then word store 0xDEADBEEF @0x1000 with no loads: next cycle ram_WE=1, A=0x1000, dataType=00, WD=0xDEADBEEF; then count=0.
- Halfword store 0xABCD @0x1010: two consecutive byte writes, WD=0xCD @0x1010 then WD=0xAB @0x1011. count drops only after the second write.
- Fill 4 stores with drain blocked by continuous missing loads to 0x2000: st_ready=0 at count=4; a 5th store is dropped. After the loads stop, 4 drain cycles occur in FIFO order.
- Word store 0x11223344 @0x1000, then byte load @0x1000 the next cycle: ld_hit=1, fwd_data=0x00000044, and the drain occurs in the same cycle.
- Byte store 0x55 @0x1001, then word load @0x1000: ld_stall=1 until the entry drains, then ld_hit=0 and ram_A=0x1000.
- Two word stores @0x1000, 0x1 then 0x2, then word load @0x1000: ld_hit=1, fwd_data=0x00000002 (youngest entry wins).

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-access types for the store buffer and its comparators.
// Access size encoding matches the RAM dataType port.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_BYTE = 2'b01,
    MEM_HALF = 2'b10
  } mem_type_t;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;

  typedef struct packed {
    logic              valid;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] data;
    mem_type_t         typ;
  } sb_entry_t;

  // Encoding 11 is not a legal size and falls back to word.
  function automatic logic [2:0] type_size(mem_type_t t);
    case (t)
      MEM_BYTE: type_size = 3'd1;
      MEM_HALF: type_size = 3'd2;
      default:  type_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/sb_overlap.sv
// Byte-range comparator between one buffered store and a load.
// Spans wrap modulo 2^AW.
module sb_overlap #(
  parameter int AW = 32
) (
  input  logic [AW-1:0] ent_addr,
  input  logic [1:0]    ent_type,
  input  logic [AW-1:0] ld_addr,
  input  logic [1:0]    ld_type,
  output logic          overlap,
  output logic          exact_cover
);
  import mem_pkg::*;

  logic [2:0]    es;
  logic [2:0]    ls;
  logic [AW-1:0] d_el;
  logic [AW-1:0] d_le;

  assign es   = type_size(mem_type_t'(ent_type));
  assign ls   = type_size(mem_type_t'(ld_type));
  assign d_el = ent_addr - ld_addr;
  assign d_le = ld_addr - ent_addr;

  // Two wrapped spans meet iff either start lies inside the other span.
  assign overlap = (d_el < {{(AW-3){1'b0}}, ls}) ||
                   (d_le < {{(AW-3){1'b0}}, es});

  assign exact_cover = (ent_addr == ld_addr) && (es >= ls);

endmodule

// File: rtl/store_buffer.sv
// FIFO of committed stores draining to the data RAM when loads leave it idle.
// Overlapping loads are forwarded from the youngest entry or stalled.
module store_buffer #(
  parameter int DEPTH         = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDRESS_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0]    st_data,
  input  logic [1:0]               st_type,
  input  logic                     ld_valid,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  input  logic [1:0]               ld_type,
  output logic                     ld_hit,
  output logic                     ld_stall,
  output logic [DATA_WIDTH-1:0]    fwd_data,
  output logic                     ram_WE,
  output logic [ADDRESS_WIDTH-1:0] ram_A,
  output logic [DATA_WIDTH-1:0]    ram_WD,
  output logic [1:0]               ram_dataType,
  output logic [$clog2(DEPTH):0]   count
);
  import mem_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0]    data_q [DEPTH];
  logic [1:0]               type_q [DEPTH];

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             half_q, half_d;

  logic [DEPTH-1:0] ovl;
  logic [DEPTH-1:0] cov;
  logic             found;
  logic [PW-1:0]    sel;
  logic             load_act;
  logic             drain;
  logic             enq;
  logic             deq;
  logic             h_half;
  logic             h_byte;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ovl
    sb_overlap #(.AW(ADDRESS_WIDTH)) u_ovl (
      .ent_addr    (addr_q[i]),
      .ent_type    (type_q[i]),
      .ld_addr     (ld_addr),
      .ld_type     (ld_type),
      .overlap     (ovl[i]),
      .exact_cover (cov[i])
    );
  end

  // Youngest first: scan from tail-1 back toward head.
  always_comb begin
    logic [PW-1:0] idx;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      idx = tail_q - PW'(k);
      if (!found && valid_q[idx] && ovl[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign load_act = ld_valid && !st_valid;
  assign ld_hit   = load_act && found && cov[sel];
  assign ld_stall = load_act && found && !cov[sel];
  assign st_ready = count_q < CW'(DEPTH);
  assign count    = count_q;

  assign h_half = type_q[head_q] == MEM_HALF;
  assign h_byte = type_q[head_q] == MEM_BYTE;
  assign drain  = (count_q != '0) && !(load_act && !found);
  assign deq    = drain && !(h_half && !half_q);
  assign enq    = st_valid && st_ready;

  always_comb begin
    fwd_data = '0;
    if (ld_hit) begin
      unique case (1'b1)
        ld_type == MEM_BYTE: fwd_data[7:0]  = data_q[sel][7:0];
        ld_type == MEM_HALF: fwd_data[15:0] = data_q[sel][15:0];
        default:             fwd_data       = data_q[sel];
      endcase
    end
  end

  always_comb begin
    ram_WE       = 1'b0;
    ram_A        = ld_addr;
    ram_dataType = ld_type;
    ram_WD       = '0;
    if (drain) begin
      ram_WE = 1'b1;
      ram_A  = addr_q[head_q];
      unique case (1'b1)
        h_byte: begin
          ram_dataType = MEM_BYTE;
          ram_WD[7:0]  = data_q[head_q][7:0];
        end
        h_half: begin
          // The RAM has no halfword write; emit two byte writes.
          ram_dataType = MEM_BYTE;
          if (half_q) begin
            ram_A       = addr_q[head_q] + ADDRESS_WIDTH'(1);
            ram_WD[7:0] = data_q[head_q][15:8];
          end else begin
            ram_WD[7:0] = data_q[head_q][7:0];
          end
        end
        default: begin
          ram_dataType = MEM_WORD;
          ram_WD       = data_q[head_q];
        end
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    half_d  = half_q;
    if (drain && h_half) half_d = !half_q;
    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end
    if (enq && !deq) count_d = count_q + CW'(1);
    if (deq && !enq) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      half_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      half_q  <= half_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
      type_q[tail_q] <= st_type;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random
// traffic checked against a byte-level queue model.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [1:0]  st_type = '0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [1:0]  ld_type = '0;
  logic        ld_hit;
  logic        ld_stall;
  logic [31:0] fwd_data;
  logic        ram_WE;
  logic [31:0] ram_A;
  logic [31:0] ram_WD;
  logic [1:0]  ram_dataType;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_type(st_type),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_type(ld_type),
    .ld_hit(ld_hit), .ld_stall(ld_stall), .fwd_data(fwd_data),
    .ram_WE(ram_WE), .ram_A(ram_A), .ram_WD(ram_WD),
    .ram_dataType(ram_dataType), .count(count)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  t;
  } ent_t;

  ent_t q[$];
  bit   ph;

  bit          e_we, e_hit, e_stall, e_rdy, m_drain;
  logic [31:0] e_a, e_wd, e_fwd;
  logic [1:0]  e_dt;
  int          e_cnt;

  function automatic int sz(logic [1:0] t);
    if (t == 2'b01) return 1;
    if (t == 2'b10) return 2;
    return 4;
  endfunction

  // Byte-by-byte comparison of the two spans.
  function automatic bit overlaps(ent_t e, logic [31:0] la, logic [1:0] lt);
    logic [31:0] lb, eb;
    for (int b = 0; b < sz(lt); b++)
      for (int c = 0; c < sz(e.t); c++) begin
        lb = la + 32'(b);
        eb = e.a + 32'(c);
        if (lb == eb) return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic predict();
    bit act;
    int s;
    act = ld_valid && !st_valid;
    s   = -1;
    if (act)
      for (int i = q.size() - 1; i >= 0; i--)
        if (overlaps(q[i], ld_addr, ld_type)) begin
          s = i;
          break;
        end
    e_hit   = act && s >= 0 && q[s].a == ld_addr && sz(q[s].t) >= sz(ld_type);
    e_stall = act && s >= 0 && !e_hit;
    e_fwd   = '0;
    if (e_hit) begin
      if (sz(ld_type) == 4) e_fwd = q[s].d;
      else e_fwd = q[s].d & ((32'd1 << (8 * sz(ld_type))) - 32'd1);
    end
    m_drain = q.size() > 0 && !(act && s < 0);
    e_we    = m_drain;
    e_a     = ld_addr;
    e_dt    = ld_type;
    e_wd    = '0;
    if (m_drain) begin
      e_a = q[0].a;
      if (q[0].t == 2'b01) begin
        e_dt = 2'b01;
        e_wd = {24'b0, q[0].d[7:0]};
      end else if (q[0].t == 2'b10) begin
        e_dt = 2'b01;
        e_a  = ph ? q[0].a + 32'd1 : q[0].a;
        e_wd = ph ? {24'b0, q[0].d[15:8]} : {24'b0, q[0].d[7:0]};
      end else begin
        e_dt = 2'b00;
        e_wd = q[0].d;
      end
    end
    e_rdy = q.size() < 4;
    e_cnt = q.size();
  endtask

  task automatic commit();
    ent_t n;
    if (m_drain) begin
      if (q[0].t == 2'b10 && !ph) ph = 1'b1;
      else begin
        ph = 1'b0;
        void'(q.pop_front());
      end
    end
    if (st_valid && e_rdy) begin
      n.a = st_addr;
      n.d = st_data;
      n.t = st_type;
      q.push_back(n);
    end
  endtask

  task automatic drive(input bit sv, input logic [31:0] sa,
                       input logic [31:0] sd, input logic [1:0] stt,
                       input bit lv, input logic [31:0] la,
                       input logic [1:0] lt);
    @(negedge clk);
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    st_type  = stt;
    ld_valid = lv;
    ld_addr  = la;
    ld_type  = lt;
    #1;
    predict();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    st_valid = 1'b0;
    ld_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    ph = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (ram_WE !== 1'b0 || ld_hit !== 1'b0 || ld_stall !== 1'b0 ||
        fwd_data !== 32'h0 || st_ready !== 1'b1 || count !== 3'd0) begin
      bad++;
      $display("FAIL reset: we=%b hit=%b stall=%b fwd=%h rdy=%b cnt=%0d want 0 0 0 0 1 0",
               ram_WE, ld_hit, ld_stall, fwd_data, st_ready, count);
    end
    rst = 1'b0;
    q.delete();
    ph = 1'b0;
  endtask

  task automatic test_word();
    do_reset();
    drive(1, 32'h1000, 32'hDEADBEEF, 2'b00, 0, 32'h0, 2'b00);
    total++;
    if (ram_WE !== 1'b0 || count !== 3'd0) begin
      bad++;
      $display("FAIL word_enq: we=%b cnt=%0d want 0 0", ram_WE, count);
    end
    commit();
    drive(0, 0, 0, 0, 0, 32'h0, 2'b00);
    total++;
    if (ram_WE !== 1'b1 || ram_A !== 32'h1000 || ram_dataType !== 2'b00 ||
        ram_WD !== 32'hDEADBEEF || count !== 3'd1) begin
      bad++;
      $display("FAIL word_drain: we=%b A=%h dt=%b WD=%h cnt=%0d want 1 1000 00 deadbeef 1",
               ram_WE, ram_A, ram_dataType, ram_WD, count);
    end
    commit();
    drive(0, 0, 0, 0, 0, 32'h0, 2'b00);
    total++;
    if (count !== 3'd0 || ram_WE !== 1'b0) begin
      bad++;
      $display("FAIL word_empty: cnt=%0d we=%b want 0 0", count, ram_WE);
    end
    commit();
  endtask

  task automatic test_half();
    do_reset();
    drive(1, 32'h1010, 32'h0000ABCD, 2'b10, 0, 32'h0, 2'b00);
    commit();
    drive(0, 0, 0, 0, 0, 32'h0, 2'b00);
    total++;
    if (ram_WE !== 1'b1 || ram_A !== 32'h1010 || ram_dataType !== 2'b01 ||
        ram_WD !== 32'hCD || count !== 3'd1) begin
      bad++;
      $display("FAIL half_lo: we=%b A=%h dt=%b WD=%h cnt=%0d want 1 1010 01 cd 1",
               ram_WE, ram_A, ram_dataType, ram_WD, count);
    end
    commit();
    drive(0, 0, 0, 0, 0, 32'h0, 2'b00);
    total++;
    if (ram_WE !== 1'b1 || ram_A !== 32'h1011 || ram_dataType !== 2'b01 ||
        ram_WD !== 32'hAB || count !== 3'd1) begin
      bad++;
      $display("FAIL half_hi: we=%b A=%h dt=%b WD=%h cnt=%0d want 1 1011 01 ab 1",
               ram_WE, ram_A, ram_dataType, ram_WD, count);
    end
    commit();
    drive(0, 0, 0, 0, 0, 32'h0, 2'b00);
    total++;
    if (count !== 3'd0) begin
      bad++;
      $display("FAIL half_done: cnt=%0d want 0", count);
    end
    commit();
  endtask

  task automatic test_fill();
    bit seen_drop = 1'b0;
    int n;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1, 32'h1100 + 32'(8 * i), 32'h100 + 32'(i), 2'b10, 0, 32'h0, 2'b00);
      if (i == 6) begin
        total++;
        if (st_ready !== 1'b0 || count !== 3'd4) begin
          bad++;
          $display("FAIL fill_full: rdy=%b cnt=%0d want 0 4", st_ready, count);
        end
      end
      commit();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 32'h2000, 2'b00);
      total++;
      if (ram_WE !== 1'b0 || ram_A !== 32'h2000 || count !== 3'd3) begin
        bad++;
        $display("FAIL fill_block: we=%b A=%h cnt=%0d want 0 2000 3",
                 ram_WE, ram_A, count);
      end
      commit();
    end
    n = 0;
    while (q.size() > 0 && n < 10) begin
      drive(0, 0, 0, 0, 0, 32'h0, 2'b00);
      if (ram_WE && ram_A[31:4] == 28'h113) seen_drop = 1'b1;
      total++;
      if (ram_WE !== 1'b1 || ram_A !== e_a || ram_WD !== e_wd ||
          count !== 3'(e_cnt)) begin
        bad++;
        $display("FAIL fill_order: we=%b A=%h WD=%h cnt=%0d want 1 %h %h %0d",
                 ram_WE, ram_A, ram_WD, count, e_a, e_wd, e_cnt);
      end
      commit();
      n++;
    end
    drive(0, 0, 0, 0, 0, 32'h0, 2'b00);
    total++;
    if (count !== 3'd0 || n != 6 || seen_drop) begin
      bad++;
      $display("FAIL fill_end: cnt=%0d writes=%0d dropped_written=%b want 0 6 0",
               count, n, seen_drop);
    end
    commit();
  endtask

  task automatic test_fwd();
    do_reset();
    drive(1, 32'h1000, 32'h11223344, 2'b00, 0, 32'h0, 2'b00);
    commit();
    drive(0, 0, 0, 0, 1, 32'h1000, 2'b01);
    total++;
    if (ld_hit !== 1'b1 || ld_stall !== 1'b0 || fwd_data !== 32'h44 ||
        ram_WE !== 1'b1 || ram_A !== 32'h1000) begin
      bad++;
      $display("FAIL fwd_byte: hit=%b stall=%b fwd=%h we=%b A=%h want 1 0 44 1 1000",
               ld_hit, ld_stall, fwd_data, ram_WE, ram_A);
    end
    commit();
  endtask

  task automatic test_stall();
    do_reset();
    drive(1, 32'h1001, 32'h55, 2'b01, 0, 32'h0, 2'b00);
    commit();
    drive(0, 0, 0, 0, 1, 32'h1000, 2'b00);
    total++;
    if (ld_stall !== 1'b1 || ld_hit !== 1'b0 || ram_WE !== 1'b1 ||
        ram_A !== 32'h1001) begin
      bad++;
      $display("FAIL stall_on: stall=%b hit=%b we=%b A=%h want 1 0 1 1001",
               ld_stall, ld_hit, ram_WE, ram_A);
    end
    commit();
    drive(0, 0, 0, 0, 1, 32'h1000, 2'b00);
    total++;
    if (ld_stall !== 1'b0 || ld_hit !== 1'b0 || ram_WE !== 1'b0 ||
        ram_A !== 32'h1000 || ram_dataType !== 2'b00) begin
      bad++;
      $display("FAIL stall_off: stall=%b hit=%b we=%b A=%h dt=%b want 0 0 0 1000 00",
               ld_stall, ld_hit, ram_WE, ram_A, ram_dataType);
    end
    commit();
  endtask

  task automatic test_youngest();
    do_reset();
    drive(1, 32'h1000, 32'h1, 2'b00, 0, 32'h0, 2'b00);
    commit();
    drive(1, 32'h1000, 32'h2, 2'b00, 0, 32'h0, 2'b00);
    commit();
    drive(0, 0, 0, 0, 1, 32'h1000, 2'b00);
    total++;
    if (ld_hit !== 1'b1 || fwd_data !== 32'h2) begin
      bad++;
      $display("FAIL young_word: hit=%b fwd=%h want 1 2", ld_hit, fwd_data);
    end
    commit();
    do_reset();
    drive(1, 32'h1000, 32'h1111, 2'b10, 0, 32'h0, 2'b00);
    commit();
    drive(1, 32'h1000, 32'h2222, 2'b10, 0, 32'h0, 2'b00);
    commit();
    drive(0, 0, 0, 0, 1, 32'h1000, 2'b10);
    total++;
    if (count !== 3'd2 || ld_hit !== 1'b1 || fwd_data !== 32'h2222) begin
      bad++;
      $display("FAIL young_half: cnt=%0d hit=%b fwd=%h want 2 1 2222",
               count, ld_hit, fwd_data);
    end
    commit();
  endtask

  task automatic test_both();
    do_reset();
    drive(1, 32'h1200, 32'hCAFEF00D, 2'b00, 0, 32'h0, 2'b00);
    commit();
    drive(1, 32'h1300, 32'h77, 2'b01, 1, 32'h1200, 2'b00);
    total++;
    if (ld_hit !== 1'b0 || ld_stall !== 1'b0 || ram_WE !== 1'b1 ||
        ram_A !== 32'h1200) begin
      bad++;
      $display("FAIL both: hit=%b stall=%b we=%b A=%h want 0 0 1 1200",
               ld_hit, ld_stall, ram_WE, ram_A);
    end
    commit();
  endtask

  task automatic test_rst_mid();
    do_reset();
    drive(1, 32'h1400, 32'hBEEF, 2'b10, 0, 32'h0, 2'b00);
    commit();
    drive(0, 0, 0, 0, 0, 32'h0, 2'b00);
    total++;
    if (ram_WE !== 1'b1 || ram_A !== 32'h1400 || ram_WD !== 32'hEF) begin
      bad++;
      $display("FAIL rstmid_lo: we=%b A=%h WD=%h want 1 1400 ef",
               ram_WE, ram_A, ram_WD);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    ph = 1'b0;
    #1;
    total++;
    if (ram_WE !== 1'b0 || count !== 3'd0 || st_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_flush: we=%b cnt=%0d rdy=%b want 0 0 1",
               ram_WE, count, st_ready);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      drive(r <= 3 || r == 8,
            32'h3000 + 32'($urandom_range(0, 15)), $urandom,
            2'($urandom_range(0, 3)),
            r >= 4 && r <= 8,
            32'h3000 + 32'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)));
      total++;
      if (ld_hit !== e_hit || ld_stall !== e_stall || fwd_data !== e_fwd ||
          ram_WE !== e_we || ram_A !== e_a || ram_dataType !== e_dt ||
          (e_we && ram_WD !== e_wd) || st_ready !== e_rdy ||
          count !== 3'(e_cnt)) begin
        bad++;
        $display("FAIL rand[%0d]: hit=%b/%b stall=%b/%b fwd=%h/%h we=%b/%b A=%h/%h dt=%b/%b WD=%h/%h rdy=%b/%b cnt=%0d/%0d",
                 i, ld_hit, e_hit, ld_stall, e_stall, fwd_data, e_fwd,
                 ram_WE, e_we, ram_A, e_a, ram_dataType, e_dt,
                 ram_WD, e_wd, st_ready, e_rdy, count, e_cnt);
      end
      commit();
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_half();
    test_fill();
    test_fwd();
    test_stall();
    test_youngest();
    test_both();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
